bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one shift per clock.
- Sits directly downstream of the 8-bit counter. It takes the counter's `count` value and produces packed BCD digits for the seven-segment/display stage.
- Uses a valid/ready input handshake and a one-cycle `out_valid` result pulse. The result is held stable between conversions.

---
 rtl/bin2bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble), one
//   shift per clock. Sits after the 8-bit counter and feeds the display stage.
//
//   Optional build macro: BIN2BCD_AUTO_CONV_EN
//     defined   : in_valid is ignored; a conversion starts automatically in
//                 IDLE whenever bin_i differs from the last accepted value.
//     undefined : conversions start only via the in_valid handshake.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bin_i     in   [WIDTH-1:0]    binary value to convert
//   in_valid  in   request to convert bin_i
//   in_ready  out  idle, able to accept
//   bcd       out  [4*DIGITS-1:0] packed BCD, digit 0 (units) in bits [3:0]
//   out_valid out  one-cycle pulse when bcd is updated
//   busy      out  conversion in progress (== !in_ready)
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_nxt;
    logic [CW-1:0]         cnt;
    logic                  start;
    logic                  last_shift;

`ifdef BIN2BCD_AUTO_CONV_EN
    logic [WIDTH-1:0]      last_bin;
    logic                  unused_in_valid;

    assign unused_in_valid = in_valid;
    assign start           = (bin_i != last_bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bin <= '0;
        end else if (state == IDLE && start) begin
            last_bin <= bin_i;
        end
    end
`else
    assign start = in_valid;
`endif

    // Shift number WIDTH is the one performed while cnt still reads WIDTH-1.
    assign last_shift = (cnt == CW'(WIDTH - 1));

    // Add 3 to every scratch digit >= 5; digits never exceed 9 here, so the
    // result fits in the nibble.
    always_comb begin
        adj = scratch;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    assign scratch_nxt = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = IDLE;
                end
            end
        endcase
        busy = !in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr    <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_i;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
                    scratch <= scratch_nxt;
                    cnt     <= cnt + 1'b1;
                    if (last_shift) begin
                        bcd       <= scratch_nxt;
                        out_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    bin_i;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                out_valid;
    logic                busy;

    int errors;
    int checks;

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .DIGITS(DIGITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_i    (bin_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd      (bcd),
        .out_valid(out_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Waits up to maxc falling edges for out_valid; returns the cycle index or -1.
    task automatic wait_out(input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        bin_i    = '0;
        in_valid = 1'b0;
        #2;
        checks++;
        if (bcd !== 12'h000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: bcd=%h ov=%b rdy=%b busy=%b, want 000 0 1 0",
                     bcd, out_valid, in_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifndef BIN2BCD_AUTO_CONV_EN
    task automatic test_max;
        int cyc;
        int bad;
        bad = 0;
        bin_i    = 8'd255;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bin_i    = 8'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL max_busy: rdy=%b busy=%b, want 0 1", in_ready, busy);
                end
            end
            if (i < 8 && (in_ready !== 1'b0 || out_valid !== 1'b0)) bad++;
            if (i < 8) @(negedge clk);
        end
        cyc = 0;
        for (int i = 8; i <= 8; i++) begin
            @(negedge clk);
            cyc = i;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_shift_phase: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (out_valid !== 1'b1 || bcd !== 12'h255 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_result: ov=%b bcd=%h rdy=%b, want 1 255 1", out_valid, bcd, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || bcd !== 12'h255) begin
            errors++;
            $display("FAIL max_pulse_hold: ov=%b bcd=%h, want 0 255", out_valid, bcd);
        end
    endtask

    task automatic test_busy_ignored;
        int cyc;
        int extra;
        bin_i    = 8'd99;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bin_i    = 8'd200;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(20, cyc);
        checks++;
        if (cyc != 5 || bcd !== 12'h099) begin
            errors++;
            $display("FAIL busy_ignored: cyc=%0d bcd=%h, want 5 099", cyc, bcd);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) extra++;
        end
        checks++;
        if (extra != 0 || bcd !== 12'h099) begin
            errors++;
            $display("FAIL busy_no_second: extra=%0d bcd=%h, want 0 099", extra, bcd);
        end
    endtask

    task automatic test_back_to_back;
        int c1;
        int c2;
        bin_i    = 8'd128;
        in_valid = 1'b1;
        @(negedge clk);
        bin_i = 8'd7;
        wait_out(20, c1);
        checks++;
        if (c1 != 8 || bcd !== 12'h128) begin
            errors++;
            $display("FAIL b2b_first: cyc=%0d bcd=%h, want 8 128", c1, bcd);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ov=%b rdy=%b, want 0 0", out_valid, in_ready);
        end
        wait_out(20, c2);
        checks++;
        if (c2 != 8 || bcd !== 12'h007) begin
            errors++;
            $display("FAIL b2b_second: cyc=%0d (spacing %0d) bcd=%h, want 8 (9) 007",
                     c2, c2 + 1, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        int extra;
        bin_i    = 8'd42;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd !== 12'h000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: bcd=%h ov=%b rdy=%b, want 000 0 1", bcd, out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) extra++;
        end
        checks++;
        if (extra != 0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_abandon: extra=%0d bcd=%h, want 0 000", extra, bcd);
        end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(20, cyc);
        checks++;
        if (cyc != 8 || bcd !== 12'h042) begin
            errors++;
            $display("FAIL reset_mid_reconvert: cyc=%0d bcd=%h, want 8 042", cyc, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int cyc;
        int v;
        for (int n = 0; n < 24; n++) begin
            v = (n == 0) ? 0 : int'($urandom_range(0, 255));
            bin_i    = WIDTH'(v);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            cyc = -1;
            for (int i = 1; i <= 20; i++) begin
                bin_i = WIDTH'($urandom);
                if ($urandom_range(0, 1) == 1) in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                if (out_valid) begin
                    cyc = i;
                    break;
                end
            end
            checks++;
            if (cyc != 8 || bcd !== ref_bcd(v)) begin
                errors++;
                $display("FAIL random_conv[%0d]: in=%0d cyc=%0d bcd=%h, want 8 %h",
                         n, v, cyc, bcd, ref_bcd(v));
            end
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask
`else
    task automatic test_auto_conv;
        int cyc;
        int extra;
        in_valid = 1'b0;
        bin_i    = 8'd9;
        wait_out(20, cyc);
        checks++;
        if (cyc != 9 || bcd !== 12'h009) begin
            errors++;
            $display("FAIL auto_first: cyc=%0d bcd=%h, want 9 009", cyc, bcd);
        end
        bin_i = 8'd10;
        wait_out(20, cyc);
        checks++;
        if (cyc != 9 || bcd !== 12'h010) begin
            errors++;
            $display("FAIL auto_second: cyc=%0d bcd=%h, want 9 010", cyc, bcd);
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            in_valid = WIDTH'($urandom_range(0, 1)) != 0;
            @(negedge clk);
            if (out_valid || !in_ready) extra++;
        end
        in_valid = 1'b0;
        checks++;
        if (extra != 0 || bcd !== 12'h010) begin
            errors++;
            $display("FAIL auto_repeat: extra=%0d bcd=%h, want 0 010", extra, bcd);
        end
    endtask

    task automatic test_random;
        int cyc;
        int v;
        for (int n = 0; n < 16; n++) begin
            v = int'($urandom_range(0, 255));
            if (WIDTH'(v) == bin_i) v = (v + 1) % 256;
            bin_i = WIDTH'(v);
            wait_out(20, cyc);
            checks++;
            if (cyc != 9 || bcd !== ref_bcd(v)) begin
                errors++;
                $display("FAIL auto_random[%0d]: in=%0d cyc=%0d bcd=%h, want 9 %h",
                         n, v, cyc, bcd, ref_bcd(v));
            end
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
`ifndef BIN2BCD_AUTO_CONV_EN
        test_max();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
`else
        test_auto_conv();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
